// File: rtl/lopd_arb_pkg.sv
// Shared types and constants for the round-robin leading-one detector arbiter.
// lopd_res_t matches the default build (I_W=16, N_REQ=4).
package lopd_arb_pkg;

  localparam int I_W_DEF     = 16;
  localparam int N_REQ_DEF   = 4;
  localparam int STALL_CNT_W = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_width(N_REQ_DEF);
  localparam int P_W_DEF  = $clog2(I_W_DEF);

  typedef struct packed {
    logic [ID_W_DEF-1:0] id;
    logic [P_W_DEF-1:0]  pos;
    logic [I_W_DEF-1:0]  norm;
    logic                zero;
  } lopd_res_t;

endpackage

// File: rtl/lopd.sv
// Leading-one position detector: index of the highest set bit, zero flag for an all-zero operand.
module lopd #(
  parameter int I_W = 16,
  parameter int P_W = $clog2(I_W)
) (
  input  logic [I_W-1:0] i_data,
  output logic [P_W-1:0] o_pos,
  output logic           o_zero
);

  always_comb begin
    o_pos  = '0;
    o_zero = (i_data == '0);
    for (int i = 0; i < I_W; i++) begin
      if (i_data[i]) o_pos = P_W'(i);
    end
  end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin pick: first valid requester at or above the pointer, wrapping modulo N_REQ.
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  int k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    k       = 0;
    // Scan from the farthest offset down so the nearest valid requester wins last.
    if (i_en) begin
      for (int off = N_REQ - 1; off >= 0; off--) begin
        k = (int'(i_ptr) + off) % N_REQ;
        if (i_valid[k]) begin
          o_grant    = '0;
          o_grant[k] = 1'b1;
          o_idx      = ID_W'(k);
          o_any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lopd_rr_arbiter.sv
// Round-robin arbiter sharing one lopd among N_REQ requesters; registered, ID-tagged result.
// Build option LOPD_ARB_STALL_CNT_EN adds a saturating output-stall counter on o_stall_cnt.
module lopd_rr_arbiter
  import lopd_arb_pkg::*;
#(
  parameter  int I_W   = 16,
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ),
  localparam int P_W   = $clog2(I_W)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [N_REQ-1:0]       i_req_valid,
  input  logic [N_REQ*I_W-1:0]   i_req_data,
  output logic [N_REQ-1:0]       o_req_ready,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [ID_W-1:0]        o_res_id,
  output logic [P_W-1:0]         o_res_pos,
  output logic [I_W-1:0]         o_res_norm,
  output logic                   o_res_zero,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  pos;
    logic [I_W-1:0]  norm;
    logic            zero;
  } res_t;

  res_t            res_q, res_d;
  logic            res_valid_q, res_valid_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic             can_accept;
  logic             grant_en;
  logic             grant_any;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic [I_W-1:0]   op;
  logic [P_W-1:0]   op_pos;
  logic             op_zero;
  logic [P_W-1:0]   shamt;

  assign can_accept = !res_valid_q || i_res_ready;
  // No grant may escape while reset is held, even though the result register is already empty.
  assign grant_en   = can_accept && i_rstn;

  rr_grant #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_grant (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .i_en    (grant_en),
    .o_grant (grant),
    .o_idx   (grant_idx),
    .o_any   (grant_any)
  );

  assign o_req_ready = grant;
  assign op          = i_req_data[grant_idx*I_W +: I_W];

  lopd #(
    .I_W (I_W),
    .P_W (P_W)
  ) u_lopd (
    .i_data (op),
    .o_pos  (op_pos),
    .o_zero (op_zero)
  );

  assign shamt = P_W'(I_W - 1) - op_pos;

  always_comb begin
    res_d       = res_q;
    res_valid_d = res_valid_q;
    ptr_d       = ptr_q;
    if (grant_any) begin
      res_d.id    = grant_idx;
      res_d.pos   = op_pos;
      res_d.norm  = op << shamt;
      res_d.zero  = op_zero;
      res_valid_d = 1'b1;
      ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (i_res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign o_res_valid = res_valid_q;
  assign o_res_id    = res_q.id;
  assign o_res_pos   = res_q.pos;
  assign o_res_norm  = res_q.norm;
  assign o_res_zero  = res_q.zero;

`ifdef LOPD_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (res_valid_q && !i_res_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
